// File: rtl/reg_dump_reader_pkg.sv
// Shared types and defaults for the register-file dump reader.
package reg_dump_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int REG_COUNT  = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Command, register-file read port and output stream of the dump reader.
// REG_DUMP_CHECKSUM_EN adds the running checksum output.
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              abort;
  logic [ADDR_W-1:0] rf_r_addr;
  logic [DATA_W-1:0] rf_r_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  modport slave (
    input  start, first_addr, last_addr, abort, rf_r_data, out_ready,
    output rf_r_addr, out_valid, out_data, out_addr, out_last, busy, done
`ifdef REG_DUMP_CHECKSUM_EN
    , output checksum
`endif
  );

  modport master (
    output start, first_addr, last_addr, abort, rf_r_data, out_ready,
    input  rf_r_addr, out_valid, out_data, out_addr, out_last, busy, done
`ifdef REG_DUMP_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/reg_dump_out_stage.sv
// Output word register with valid/ready hold; fields only change on load.
module reg_dump_out_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              last_i,
  output logic              can_load_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;

  // Empty slot or word leaving this edge: a new word may enter with no bubble.
  assign can_load_o = !valid_q || ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      addr_q  <= addr_i;
      last_q  <= last_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;
endmodule

// File: rtl/reg_dump_reader.sv
// Walks first..last (wrapping) through one register-file read port and streams words out.
// REG_DUMP_CHECKSUM_EN adds a running sum of transferred words.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic               clk,
  input logic               reset,
  reg_dump_reader_if.slave  bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] hold_q;
  logic              done_q;
  logic              can_load;
  logic              load;
  logic              clr;
  logic              active;

  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign load   = (state_q == RUN) && can_load && !bus.abort;
  assign clr    = (active && bus.abort) || ((state_q == DRAIN) && bus.out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ptr_q   <= bus.first_addr;
            last_q  <= bus.last_addr;
            state_q <= RUN;
          end
        end
        RUN: begin
          hold_q <= ptr_q;
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (load) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (ptr_q == last_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (bus.out_ready) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outside RUN the read address freezes at the last address actually read.
  assign bus.rf_r_addr = (state_q == RUN) ? ptr_q : hold_q;
  assign bus.busy      = active;
  assign bus.done      = done_q;

  reg_dump_out_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_out (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .clr_i      (clr),
    .ready_i    (bus.out_ready),
    .data_i     (bus.rf_r_data),
    .addr_i     (ptr_q),
    .last_i     (ptr_q == last_q),
    .can_load_o (can_load),
    .valid_o    (bus.out_valid),
    .data_o     (bus.out_data),
    .addr_o     (bus.out_addr),
    .last_o     (bus.out_last)
  );

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      csum_q <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      csum_q <= csum_q + bus.out_data;
    end
  end

  assign bus.checksum = csum_q;
`endif
endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: the bench is the register file and a queue-based reference.
module tb_reg_dump_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rf [32];
  int          n_chk = 0;
  int          n_err = 0;

  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus();

  reg_dump_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Address 0 of the register file always reads zero.
  assign bus.rf_r_data = (bus.rf_r_addr == 5'd0) ? 32'h0 : rf[bus.rf_r_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. mode: 0 ready high, 1 random ready, 2 ready low for the first six observations.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode, input bit bstart);
    logic [4:0]  qa [$];
    logic [31:0] qd [$];
    logic [31:0] sum;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] pd;
    logic [4:0]  pa;
    logic        pl;
    int          cnt;
    int          idx;
    int          cyc;
    bit          done_exp;
    bit          got;
    bit          stall;
    bit          xfer;
    sum = 0; idx = 0; cyc = 0; done_exp = 0; got = 0; stall = 0;
    pd = 0; pa = 0; pl = 0;
    cnt = ((int'(l) - int'(f) + 32) % 32) + 1;
    for (int i = 0; i < cnt; i++) begin
      a = 5'((int'(f) + i) % 32);
      d = (a == 5'd0) ? 32'h0 : rf[a];
      qa.push_back(a);
      qd.push_back(d);
      sum = sum + d;
    end
    bus.start = 1'b1; bus.first_addr = f; bus.last_addr = l;
    bus.out_ready = (mode == 0);
    @(negedge clk);
    while (!got && cyc < 400) begin
      bus.start = 1'b0;
      bus.first_addr = 5'($urandom);
      bus.last_addr  = 5'($urandom);
      if (done_exp) begin
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_valid", bus.out_valid, 0);
`ifdef REG_DUMP_CHECKSUM_EN
        chk("checksum", bus.checksum, sum);
`endif
        got = 1;
      end else begin
        chk("no_done", bus.done, 0);
        if (cyc == 0) begin
          chk("lat_valid_n1", bus.out_valid, 0);
          chk("lat_busy_n1", bus.busy, 1);
`ifdef REG_DUMP_CHECKSUM_EN
          chk("checksum_clr", bus.checksum, 0);
`endif
        end
        if (cyc == 1) chk("lat_valid_n2", bus.out_valid, 1);
        if (stall) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, pd);
          chk("hold_addr", bus.out_addr, pa);
          chk("hold_last", bus.out_last, pl);
        end
        case (mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = 1'($urandom_range(0, 1));
          default: bus.out_ready = (cyc >= 6);
        endcase
        if (bstart && cyc == 2) bus.start = 1'b1;
        xfer = bus.out_valid && bus.out_ready;
        if (xfer) begin
          if (idx < cnt) begin
            chk("word_addr", bus.out_addr, qa[idx]);
            chk("word_data", bus.out_data, qd[idx]);
            chk("word_last", bus.out_last, (idx == cnt - 1));
          end else begin
            chk("extra_word", 1, 0);
          end
          idx++;
        end
        stall = bus.out_valid && !bus.out_ready;
        pd = bus.out_data; pa = bus.out_addr; pl = bus.out_last;
        done_exp = xfer && (idx == cnt);
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", got, 1);
    chk("word_count", idx, cnt);
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.first_addr = '0; bus.last_addr = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);

    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_raddr", bus.rf_r_addr, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_addr", bus.out_addr, 0);
    chk("rst_last", bus.out_last, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic range with an ignored start mid-dump.
    run_dump(5'd3, 5'd6, 0, 1'b1);

    // Wrap 30..1; register 0 content must never appear.
    rf[0] = 32'hDEADBEEF;
    run_dump(5'd30, 5'd1, 0, 1'b0);
    chk("raddr_hold", bus.rf_r_addr, 1);

    // Full range under random backpressure with random contents.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    run_dump(5'd0, 5'd31, 1, 1'b0);

    // Single word stalled for five cycles.
    run_dump(5'd9, 5'd9, 2, 1'b0);

    // Abort after two transfers, with an ignored start in between.
    bus.start = 1'b1; bus.first_addr = 5'd5; bus.last_addr = 5'd20; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.first_addr = 5'd0; bus.last_addr = 5'd0;
    chk("ab_busy", bus.busy, 1);
    chk("ab_valid0", bus.out_valid, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ab_w0", bus.out_addr, 5);
    @(negedge clk);
    chk("ab_w1", bus.out_addr, 6);
    chk("ab_w1_valid", bus.out_valid, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab_valid", bus.out_valid, 0);
    chk("ab_idle", bus.busy, 0);
    chk("ab_no_done", bus.done, 0);
    @(negedge clk);
    chk("ab_no_done2", bus.done, 0);
    bus.start = 1'b1; bus.abort = 1'b1; bus.first_addr = 5'd2; bus.last_addr = 5'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_wins", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab2_idle", bus.busy, 0);

    // Asynchronous reset while a word is held.
    bus.start = 1'b1; bus.first_addr = 5'd7; bus.last_addr = 5'd12; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_addr", bus.out_addr, 7);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_addr", bus.out_addr, 0);
    chk("arst_last", bus.out_last, 0);
    chk("arst_raddr", bus.rf_r_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", bus.busy, 0);

    // Sum of 1..4 is 10, then a fresh start clears the sum.
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    run_dump(5'd1, 5'd4, 0, 1'b0);
    run_dump(5'd2, 5'd2, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      run_dump(5'($urandom), 5'($urandom), 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Sequential read-side client of the 32x32 register file.
- Walks a programmed address range through one register-file read port.
- Streams each word out over a valid/ready interface, one word per cycle at full throughput.
- Used for debug dumps, context save and bench scoreboarding; sits beside the datapath and drives one read-address mux input.

Parameters:
- ADDR_W, 5, register address width; the file depth is 2**ADDR_W.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- start  input  1  one-cycle request; sampled only in IDLE.
- first_addr  input  ADDR_W  first register to read; latched on accepted start.
- last_addr  input  ADDR_W  final register to read; latched on accepted start.
- abort  input  1  cancels the dump in progress.
- rf_r_addr  output  ADDR_W  read address to the register file.
- rf_r_data  input  DATA_W  combinational read data for rf_r_addr; address 0 reads 0.
- out_valid  output  1  out_* fields hold a valid word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_W  register contents.
- out_addr  output  ADDR_W  register index of out_data.
- out_last  output  1  word is the final word of the range.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: state=IDLE, ptr=0, rf_r_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0.
- States:
  - IDLE. start=1: latch last_addr, ptr<=first_addr, go to RUN. Otherwise stay.
  - RUN. rf_r_addr=ptr. Define load = !out_valid || out_ready.
    - On load: out_data<=rf_r_data, out_addr<=ptr, out_last<=(ptr==last), out_valid<=1, ptr<=ptr+1 mod 2**ADDR_W.
    - On a load with ptr==last, go to DRAIN.
  - DRAIN. Hold the final word until out_ready=1, then out_valid<=0, done<=1 for one cycle, go to IDLE.
- Latency: start accepted at cycle N. First out_valid=1 at N+2. With out_ready held high, one word per cycle after that.
- Handshake:
  - A word transfers when out_valid && out_ready on a posedge.
  - While out_valid=1 and out_ready=0, out_data, out_addr and out_last stay stable.
  - out_valid never drops without a transfer, except on abort or reset.
- Range and wrap-around:
  - Count = ((last-first) mod 2**ADDR_W)+1, so 1 to 32 words.
  - first==last gives 1 word with out_last=1.
  - last<first wraps 31 to 0; e.g. 30..1 gives 30,31,0,1.
  - Address 0 yields data 0.
- start while busy: ignored, no effect on latched range.
- abort: in RUN or DRAIN, next state is IDLE with out_valid=0 and no done pulse. In IDLE it has no effect. If abort and start both arrive in IDLE, start wins.
- Simultaneous transfer and load in RUN: the old word leaves and the new word loads in the same edge, with no bubble.
- rf_r_addr outside RUN holds its last value; the register file ignores it.
- Register-file writes during a dump: each word reflects the register contents at its load edge. There is no snapshot guarantee.
- Reset mid-operation: immediate return to reset values; the partial dump is lost.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum, DATA_W wide.
  - Cleared on accepted start.
  - Each transferred word updates it: checksum <= checksum + out_data, mod 2**DATA_W.
  - The value is final and stable from the done cycle until the next start. Abort leaves the partial sum.
  - Reset value 0.
- Without the macro: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package reg_dump_pkg:
  - state enum {IDLE, RUN, DRAIN}.
  - ADDR_W and DATA_W defaults.
  - REG_COUNT = 2**ADDR_W.
- Sub-module: reg_dump_out_stage, the output register with valid/ready hold logic. It provides load and takes data, addr and last fields. The FSM and pointer stay in the top module.

Test Plan:
- Register file just reset (reg[i]=i). start with first=3, last=6, out_ready=1 -> out_valid high from N+2 for 4 cycles; data/addr 3,4,5,6; out_last only on 6; done pulse one cycle after the 6 transfer.
- Wrap range first=30, last=1 -> data 30,31,0,1; address 0 gives data 0 even if reg[0] was written 0xDEADBEEF; out_last on addr 1.
- Backpressure: dump 0..31 with out_ready toggling in a random pattern -> all 32 words delivered once, in order; out_* stable while stalled; done exactly once.
- Single word first=last=9 with out_ready=0 for 5 cycles -> word 9 with out_last=1 held; done one cycle after out_ready rises.
- start while busy, abort in RUN after 2 transfers, then reset pulled low mid-dump -> second start ignored; abort gives out_valid=0 next cycle with no done; reset clears all outputs asynchronously.
- REG_DUMP_CHECKSUM_EN with reg[i]=i, first=1, last=4 -> checksum=10 at done; a subsequent start clears it to 0.
